// File: rtl/i2c_slave_byte_ctrl.sv
// i2c_slave_byte_ctrl
// Byte-level I2C target controller. It decodes START, STOP and repeated START,
// matches a 7-bit own address, shifts bytes in (master write) and out (master
// read), answers with ACK/NACK, and stretches SCL while waiting for TX data.
//
// Ports
//   clk_i, rst_i            system clock, synchronous active-high reset
//   ena_i                   block enable (0 = FSM parked in IDLE, lines released)
//   slv_addr_i[6:0]         own address
//   ack_en_i                ACK (1) / NACK (0) for master-write data bytes
//   rx_dat_o[7:0]           last received data byte
//   rx_valid_o              one-cycle pulse per received data byte
//   tx_req_o                level, next transmit byte wanted
//   tx_valid_i, tx_dat_i    transmit byte handshake (tx_req_o && tx_valid_i)
//   start_o, stop_o         one-cycle pulses on bus START / STOP
//   sel_o, rw_o             addressed flag and R/W bit of the matched address
//   nack_o                  one-cycle pulse when the master NACKs a sent byte
//   busy_o                  bus busy between START and STOP
//   scl_i, sda_i            pad inputs
//   scl_o, sda_o            pad outputs, tied to 0 (open drain)
//   scl_dir_o, sda_dir_o    1 = pull the pad low, 0 = release
module i2c_slave_byte_ctrl #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ena_i,
  input  logic [6:0] slv_addr_i,
  input  logic       ack_en_i,
  output logic [7:0] rx_dat_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_dat_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       sel_o,
  output logic       rw_o,
  output logic       nack_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_dir_o,
  output logic       sda_dir_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0] sync1, sync2, filt, filt_d;
  logic [3:0] flt_cnt [2];

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, handshake;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [7:0] shreg_q, shreg_n, rx_dat_q, rx_dat_n;
  logic       rx_valid_q, rx_valid_n, start_q, start_n, stop_q, stop_n;
  logic       nack_q, nack_n, sel_q, sel_n, rw_q, rw_n, busy_q, busy_n;
  logic       scl_dir_q, scl_dir_n, sda_dir_q, sda_dir_n;
  logic       ack_pend_q, ack_pend_n, ack_lat_q, ack_lat_n, tx_req_q, tx_req_n;

  // Two-flop synchronizer followed by a per-line glitch filter: the filtered
  // value only follows the synchronized input after FILTER_LEN consecutive
  // differing samples. Idle bus level is high, hence the reset value of 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1  <= {sda_i, scl_i};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CNT_MAX) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  // SCL must be high both now and in the previous cycle: an SDA change that
  // coincides with our own release of a stretched SCL is data, not a START/STOP.
  assign start_det = filt_d[1] & ~filt[1] & filt[0] & filt_d[0];
  assign stop_det  = ~filt_d[1] & filt[1] & filt[0] & filt_d[0];
  assign handshake = tx_req_q & tx_valid_i;

  // Next-state and next-output logic for the byte FSM and its datapath.
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shreg_n    = shreg_q;
    rx_dat_n   = rx_dat_q;
    rx_valid_n = 1'b0;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    nack_n     = 1'b0;
    sel_n      = sel_q;
    rw_n       = rw_q;
    busy_n     = busy_q;
    scl_dir_n  = scl_dir_q;
    sda_dir_n  = sda_dir_q;
    ack_pend_n = ack_pend_q;
    ack_lat_n  = ack_lat_q;
    tx_req_n   = 1'b0;

    // Bus condition tracking keeps running even while the block is disabled.
    if (start_det) begin
      start_n = 1'b1;
      busy_n  = 1'b1;
    end else if (stop_det) begin
      stop_n = 1'b1;
      busy_n = 1'b0;
    end

    if (!ena_i) begin
      state_n    = IDLE;
      scl_dir_n  = 1'b0;
      sda_dir_n  = 1'b0;
      sel_n      = 1'b0;
      ack_pend_n = 1'b0;
    end else if (start_det) begin
      state_n    = ADDR;
      bit_cnt_n  = 3'd0;
      ack_pend_n = 1'b0;
      sel_n      = 1'b0;
      scl_dir_n  = 1'b0;
      sda_dir_n  = 1'b0;
    end else if (stop_det) begin
      state_n    = IDLE;
      ack_pend_n = 1'b0;
      sel_n      = 1'b0;
      scl_dir_n  = 1'b0;
      sda_dir_n  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          scl_dir_n = 1'b0;
          sda_dir_n = 1'b0;
        end
        // ack_pend marks "8 bits in, waiting for the SCL fall to drive ACK".
        ADDR: begin
          if (ack_pend_q) begin
            if (scl_fall) begin
              sda_dir_n  = 1'b1;
              ack_pend_n = 1'b0;
              state_n    = ADDR_ACK;
            end
          end else if (scl_rise) begin
            shreg_n   = {shreg_q[6:0], sda_f};
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shreg_q[6:0] == slv_addr_i) begin
                sel_n      = 1'b1;
                rw_n       = sda_f;
                ack_pend_n = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_dir_n = 1'b0;
            state_n   = rw_q ? TX_LOAD : RX;
          end
        end
        RX: begin
          if (ack_pend_q) begin
            if (scl_fall) begin
              sda_dir_n  = ack_lat_q;
              ack_pend_n = 1'b0;
              state_n    = RX_ACK;
            end
          end else if (scl_rise) begin
            shreg_n   = {shreg_q[6:0], sda_f};
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_dat_n   = {shreg_q[6:0], sda_f};
              rx_valid_n = 1'b1;
              ack_lat_n  = ack_en_i;
              ack_pend_n = 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_dir_n = 1'b0;
            state_n   = RX;
          end
        end
        // Data is only requested while SCL is low, so the MSB never changes
        // SDA during the high phase of the master's ACK clock.
        TX_LOAD: begin
          if (handshake) begin
            shreg_n   = tx_dat_i;
            bit_cnt_n = 3'd0;
            scl_dir_n = 1'b0;
            sda_dir_n = ~tx_dat_i[7];
            state_n   = TX;
          end else begin
            tx_req_n  = ~scl_f;
            scl_dir_n = scl_dir_q | ~scl_f;
          end
        end
        TX: begin
          if (scl_fall) begin
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_dir_n = 1'b0;
              state_n   = TX_ACK;
            end else begin
              shreg_n   = {shreg_q[6:0], 1'b0};
              sda_dir_n = ~shreg_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              state_n = TX_LOAD;
            end else begin
              nack_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_dat_q   <= '0;
      rx_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
      sel_q      <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      scl_dir_q  <= 1'b0;
      sda_dir_q  <= 1'b0;
      ack_pend_q <= 1'b0;
      ack_lat_q  <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shreg_q    <= shreg_n;
      rx_dat_q   <= rx_dat_n;
      rx_valid_q <= rx_valid_n;
      start_q    <= start_n;
      stop_q     <= stop_n;
      nack_q     <= nack_n;
      sel_q      <= sel_n;
      rw_q       <= rw_n;
      busy_q     <= busy_n;
      scl_dir_q  <= scl_dir_n;
      sda_dir_q  <= sda_dir_n;
      ack_pend_q <= ack_pend_n;
      ack_lat_q  <= ack_lat_n;
      tx_req_q   <= tx_req_n;
    end
  end

  assign rx_dat_o   = rx_dat_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_req_o   = tx_req_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign nack_o     = nack_q;
  assign sel_o      = sel_q;
  assign rw_o       = rw_q;
  assign busy_o     = busy_q;
  assign scl_dir_o  = scl_dir_q;
  assign sda_dir_o  = sda_dir_q;
  assign scl_o      = 1'b0;
  assign sda_o      = 1'b0;

endmodule
